mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mips_ctrl_pkg.sv | 73 +++++++
 rtl/mc_decode.sv | 50 +++++
 rtl/mc_controller.sv | 210 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared state, instruction-class, opcode/funct and ALU operation definitions
// for the multicycle MIPS controller.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_BRANCH,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_MULDIV,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JR,
    CLS_J
  } instr_class_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALUControl codes shared with the ALU decoder
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_MULT   = 5'd7;
  localparam logic [4:0] ALU_DIV    = 5'd8;
  localparam logic [4:0] ALU_PASS_A = 5'd9;
  localparam logic [4:0] ALU_EQ     = 5'd10;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct -> instruction class,
// ALU operation, immediate extension select and branch sense.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [4:0]   alu_op,
  output logic         ext_sel,
  output logic         is_bne
);

  // Classify the instruction and pick the ALU operation it uses in EXEC
  always_comb begin
    cls     = CLS_NONE;
    alu_op  = ALU_ADD;
    ext_sel = 1'b0;
    is_bne  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin cls = CLS_RTYPE;  alu_op = ALU_ADD;  end
          FN_SUBU: begin cls = CLS_RTYPE;  alu_op = ALU_SUB;  end
          FN_AND:  begin cls = CLS_RTYPE;  alu_op = ALU_AND;  end
          FN_OR:   begin cls = CLS_RTYPE;  alu_op = ALU_OR;   end
          FN_XOR:  begin cls = CLS_RTYPE;  alu_op = ALU_XOR;  end
          FN_SLT:  begin cls = CLS_RTYPE;  alu_op = ALU_SLT;  end
          FN_SLTU: begin cls = CLS_RTYPE;  alu_op = ALU_SLTU; end
          FN_MULT: begin cls = CLS_MULDIV; alu_op = ALU_MULT; end
          FN_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV;  end
          FN_JR:   begin cls = CLS_JR;     alu_op = ALU_PASS_A; end
          default: cls = CLS_NONE;
        endcase
      end
      OP_ADDIU: begin cls = CLS_ITYPE; alu_op = ALU_ADD; end
      OP_SLTI:  begin cls = CLS_ITYPE; alu_op = ALU_SLT; end
      OP_ANDI:  begin cls = CLS_ITYPE; alu_op = ALU_AND; ext_sel = 1'b1; end
      OP_ORI:   begin cls = CLS_ITYPE; alu_op = ALU_OR;  ext_sel = 1'b1; end
      OP_XORI:  begin cls = CLS_ITYPE; alu_op = ALU_XOR; ext_sel = 1'b1; end
      OP_LW:    begin cls = CLS_LOAD;  alu_op = ALU_ADD; end
      OP_SW:    begin cls = CLS_STORE; alu_op = ALU_ADD; end
      OP_BEQ:   begin cls = CLS_BRANCH; alu_op = ALU_EQ; end
      OP_BNE:   begin cls = CLS_BRANCH; alu_op = ALU_EQ; is_bne = 1'b1; end
      OP_J:     cls = CLS_J;
      default:  cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH,
// applies delayed branch/jump redirects on the next fetch, and halts when a
// fetch would start at address 0.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_PC0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        stall,
  input  logic        OUTLSB,
  input  logic        PcIs0,
  input  logic        waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  byteenable,
  output logic        active,
  output logic        PcEn,
  output logic        IorD,
  output logic        IrWrite,
  output logic        IrSel,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ExtSel,
  output logic        ALUsel,
  output logic        PCSrc,
  output logic        is_jump,
  output logic [1:0]  ALUSrcB,
  output logic [4:0]  ALUControl
);

  state_t       state, state_nxt;
  logic         pend_br, pend_br_nxt;
  logic         pend_jr, pend_jr_nxt;
  logic         pend_j,  pend_j_nxt;
  state_t       fetch_entry;

  instr_class_t dec_cls;
  logic [4:0]   dec_op;
  logic         dec_ext;
  logic         dec_bne;

  // Register and immediate fields are consumed by the datapath, not here
  logic         instr_unused;
  assign instr_unused = ^Instr[25:6];

  mc_decode u_decode (
    .opcode  (opcode_of(Instr)),
    .funct   (funct_of(Instr)),
    .cls     (dec_cls),
    .alu_op  (dec_op),
    .ext_sel (dec_ext),
    .is_bne  (dec_bne)
  );

  // Every return to FETCH is diverted to HALT when the PC is zero
  assign fetch_entry = (HALT_ON_PC0 && PcIs0) ? ST_HALT : ST_FETCH;

  // State and pending-redirect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      pend_br <= 1'b0;
      pend_jr <= 1'b0;
      pend_j  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_br <= pend_br_nxt;
      pend_jr <= pend_jr_nxt;
      pend_j  <= pend_j_nxt;
    end
  end

  // Next-state and control outputs; everything is forced low while reset is
  // asserted so an in-flight memory strobe drops immediately
  always_comb begin
    state_nxt   = state;
    pend_br_nxt = pend_br;
    pend_jr_nxt = pend_jr;
    pend_j_nxt  = pend_j;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    PcEn        = 1'b0;
    IorD        = 1'b0;
    IrWrite     = 1'b0;
    IrSel       = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ExtSel      = 1'b0;
    ALUsel      = 1'b0;
    PCSrc       = 1'b0;
    is_jump     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;

    if (reset) begin
      case (state)
        ST_FETCH: begin
          mem_read = 1'b1;
          // A pending redirect computes the new PC from the IR that still
          // holds the redirecting instruction, so IrSel stays on meanwhile
          if (pend_br) begin
            IrSel      = 1'b1;
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;
          end else if (pend_jr) begin
            IrSel      = 1'b1;
            ALUSrcA    = 1'b1;
            ALUControl = ALU_PASS_A;
          end else begin
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            if (pend_j) begin
              IrSel   = 1'b1;
              is_jump = 1'b1;
            end
          end
          if (!waitrequest) begin
            PcEn        = 1'b1;
            IrWrite     = 1'b1;
            pend_br_nxt = 1'b0;
            pend_jr_nxt = 1'b0;
            pend_j_nxt  = 1'b0;
            state_nxt   = ST_DECODE;
          end
        end

        ST_DECODE: begin
          IrSel     = 1'b1;
          state_nxt = (dec_cls == CLS_NONE) ? fetch_entry : ST_EXEC;
        end

        ST_EXEC: begin
          IrSel = 1'b1;
          case (dec_cls)
            CLS_RTYPE, CLS_MULDIV, CLS_BRANCH: begin
              ALUSrcA    = 1'b1;
              ALUSrcB    = 2'b00;
              ALUControl = dec_op;
            end
            CLS_ITYPE, CLS_LOAD, CLS_STORE: begin
              ALUSrcA    = 1'b1;
              ALUSrcB    = 2'b10;
              ExtSel     = dec_ext;
              ALUControl = dec_op;
            end
            default: ;
          endcase
          if (!stall) begin
            case (dec_cls)
              CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
              CLS_BRANCH:          state_nxt = ST_BRANCH;
              CLS_JR: begin
                pend_jr_nxt = 1'b1;
                state_nxt   = fetch_entry;
              end
              CLS_J: begin
                pend_j_nxt = 1'b1;
                state_nxt  = fetch_entry;
              end
              CLS_NONE:            state_nxt = fetch_entry;
              default:             state_nxt = ST_WB;
            endcase
          end
        end

        ST_MEM: begin
          IrSel     = 1'b1;
          IorD      = 1'b1;
          ALUsel    = 1'b1;
          mem_read  = (dec_cls == CLS_LOAD);
          mem_write = (dec_cls == CLS_STORE);
          if (!waitrequest) begin
            RegWrite  = (dec_cls == CLS_LOAD);
            state_nxt = fetch_entry;
          end
        end

        ST_WB: begin
          IrSel     = 1'b1;
          ALUsel    = 1'b1;
          MemToReg  = 1'b1;
          RegWrite  = (dec_cls != CLS_MULDIV);
          RegDst    = (dec_cls == CLS_RTYPE) || (dec_cls == CLS_MULDIV);
          state_nxt = fetch_entry;
        end

        ST_BRANCH: begin
          IrSel = 1'b1;
          if (dec_bne ? !OUTLSB : OUTLSB) pend_br_nxt = 1'b1;
          state_nxt = fetch_entry;
        end

        ST_HALT: state_nxt = ST_HALT;

        default: state_nxt = ST_FETCH;
      endcase
    end

    byteenable = (mem_read || mem_write) ? 4'hF : 4'h0;
    active     = reset && (state != ST_HALT);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks instruction sequences cycle by
// cycle and compares the full control vector against hand-derived values.
module tb_mc_controller;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [3:0] be;
    logic       active;
    logic       PcEn;
    logic       IorD;
    logic       IrWrite;
    logic       IrSel;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       ExtSel;
    logic       ALUsel;
    logic       PCSrc;
    logic       is_jump;
    logic [1:0] srcb;
    logic [4:0] op;
  } ctl_t;

  localparam logic [31:0] I_ADDIU1 = 32'h2401_0005; // addiu $1,$0,5
  localparam logic [31:0] I_ADDU   = 32'h0021_1021; // addu  $2,$1,$1
  localparam logic [31:0] I_SW     = 32'hAC02_0000; // sw    $2,0($0)
  localparam logic [31:0] I_ORI    = 32'h3403_F0F0; // ori   $3,$0,0xF0F0
  localparam logic [31:0] I_BEQ    = 32'h1000_0004; // beq   $0,$0,+4
  localparam logic [31:0] I_BNE    = 32'h1400_0004; // bne   $0,$0,+4
  localparam logic [31:0] I_DIV    = 32'h0022_001A; // div   $1,$2
  localparam logic [31:0] I_J      = 32'h0800_0010; // j     0x40
  localparam logic [31:0] I_JR     = 32'h0000_0008; // jr    $0
  localparam logic [31:0] I_LW     = 32'h8C03_0000; // lw    $3,0($0)
  localparam logic [31:0] I_BAD    = 32'hFC00_0000; // undefined opcode

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        stall, OUTLSB, PcIs0, waitrequest;
  logic        mem_read, mem_write, active, PcEn, IorD, IrWrite, IrSel;
  logic        RegDst, MemToReg, RegWrite, ALUSrcA, ExtSel, ALUsel, PCSrc, is_jump;
  logic [3:0]  byteenable;
  logic [1:0]  ALUSrcB;
  logic [4:0]  ALUControl;

  ctl_t got;
  ctl_t e;
  int   errors = 0;
  int   checks = 0;

  mc_controller #(.HALT_ON_PC0(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .stall       (stall),
    .OUTLSB      (OUTLSB),
    .PcIs0       (PcIs0),
    .waitrequest (waitrequest),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .byteenable  (byteenable),
    .active      (active),
    .PcEn        (PcEn),
    .IorD        (IorD),
    .IrWrite     (IrWrite),
    .IrSel       (IrSel),
    .RegDst      (RegDst),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ExtSel      (ExtSel),
    .ALUsel      (ALUsel),
    .PCSrc       (PCSrc),
    .is_jump     (is_jump),
    .ALUSrcB     (ALUSrcB),
    .ALUControl  (ALUControl)
  );

  assign got = {mem_read, mem_write, byteenable, active, PcEn, IorD, IrWrite,
                IrSel, RegDst, MemToReg, RegWrite, ALUSrcA, ExtSel, ALUsel,
                PCSrc, is_jump, ALUSrcB, ALUControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.active = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch(input bit acc);
    ctl_t c = idle();
    c.mem_read = 1'b1;
    c.be       = 4'hF;
    c.srcb     = 2'b01;
    c.op       = ALU_ADD;
    c.PcEn     = acc;
    c.IrWrite  = acc;
    return c;
  endfunction

  function automatic ctl_t decode();
    ctl_t c = idle();
    c.IrSel = 1'b1;
    return c;
  endfunction

  function automatic ctl_t exec_r(input logic [4:0] op);
    ctl_t c = decode();
    c.ALUSrcA = 1'b1;
    c.srcb    = 2'b00;
    c.op      = op;
    return c;
  endfunction

  function automatic ctl_t exec_i(input logic [4:0] op, input bit ext);
    ctl_t c = decode();
    c.ALUSrcA = 1'b1;
    c.srcb    = 2'b10;
    c.ExtSel  = ext;
    c.op      = op;
    return c;
  endfunction

  function automatic ctl_t wb(input bit rtype, input bit wr);
    ctl_t c = decode();
    c.ALUsel   = 1'b1;
    c.MemToReg = 1'b1;
    c.RegWrite = wr;
    c.RegDst   = rtype;
    return c;
  endfunction

  function automatic ctl_t mem(input bit ld, input bit acc);
    ctl_t c = decode();
    c.IorD      = 1'b1;
    c.ALUsel    = 1'b1;
    c.mem_read  = ld;
    c.mem_write = !ld;
    c.be        = 4'hF;
    c.RegWrite  = ld && acc;
    return c;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input ctl_t exp);
    #1;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Instr = '0; stall = 1'b0; OUTLSB = 1'b0;
    PcIs0 = 1'b0; waitrequest = 1'b0;
    #2;
    check("reset_outputs", '0);
    @(posedge clk); #1;
    check("reset_held", '0);
    reset = 1'b1;

    // addiu $1,$0,5 / addu $2,$1,$1 -- four cycles each
    Instr = I_ADDIU1;
    step("addiu_fetch", fetch(1));
    step("addiu_decode", decode());
    step("addiu_exec", exec_i(ALU_ADD, 0));
    step("addiu_wb", wb(0, 1));
    Instr = I_ADDU;
    step("addu_fetch", fetch(1));
    step("addu_decode", decode());
    step("addu_exec", exec_r(ALU_ADD));
    step("addu_wb", wb(1, 1));

    // sw with memory busy three cycles
    Instr = I_SW;
    step("sw_fetch", fetch(1));
    step("sw_decode", decode());
    step("sw_exec", exec_i(ALU_ADD, 0));
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) step("sw_mem_wait", mem(0, 0));
    waitrequest = 1'b0;
    step("sw_mem_accept", mem(0, 0));

    // ori uses zero-extended immediate
    Instr = I_ORI;
    step("ori_fetch", fetch(1));
    step("ori_decode", decode());
    step("ori_exec", exec_i(ALU_OR, 1));
    step("ori_wb", wb(0, 1));

    // beq taken; redirect fetch stalls two cycles
    Instr = I_BEQ;
    step("beq_fetch", fetch(1));
    step("beq_decode", decode());
    step("beq_exec", exec_r(ALU_EQ));
    OUTLSB = 1'b1;
    step("beq_branch", decode());
    OUTLSB = 1'b0;
    waitrequest = 1'b1;
    e = fetch(0); e.IrSel = 1'b1; e.srcb = 2'b11;
    step("beq_redirect_wait", e);
    step("beq_redirect_wait", e);
    waitrequest = 1'b0;
    e.PcEn = 1'b1; e.IrWrite = 1'b1;
    step("beq_redirect_accept", e);
    Instr = I_ADDIU1;
    step("slot_decode", decode());
    step("slot_exec", exec_i(ALU_ADD, 0));
    step("slot_wb", wb(0, 1));

    // bne with equal operands: not taken, next fetch is plain PC+4
    Instr = I_BNE;
    step("bne_fetch_plain", fetch(1));
    step("bne_decode", decode());
    step("bne_exec", exec_r(ALU_EQ));
    OUTLSB = 1'b1;
    step("bne_branch", decode());
    OUTLSB = 1'b0;

    // div stalls EXEC for ten extra cycles, no register write
    Instr = I_DIV;
    step("div_fetch_plain", fetch(1));
    step("div_decode", decode());
    stall = 1'b1;
    for (int i = 0; i < 10; i++) step("div_exec_stall", exec_r(ALU_DIV));
    stall = 1'b0;
    step("div_exec_done", exec_r(ALU_DIV));
    step("div_wb", wb(1, 0));

    // j: no ALU op in EXEC, is_jump on the delay-slot fetch
    Instr = I_J;
    step("j_fetch", fetch(1));
    step("j_decode", decode());
    step("j_exec", decode());
    e = fetch(1); e.IrSel = 1'b1; e.is_jump = 1'b1;
    step("j_redirect_fetch", e);
    Instr = I_ADDIU1;
    step("jslot_decode", decode());
    step("jslot_exec", exec_i(ALU_ADD, 0));
    step("jslot_wb", wb(0, 1));

    // jr $0: delay slot runs, then halt
    Instr = I_JR;
    step("jr_fetch", fetch(1));
    step("jr_decode", decode());
    step("jr_exec", decode());
    e = fetch(1); e.IrSel = 1'b1; e.ALUSrcA = 1'b1; e.srcb = 2'b00; e.op = ALU_PASS_A;
    step("jr_redirect_fetch", e);
    Instr = I_ADDIU1;
    PcIs0 = 1'b1;
    step("jrslot_decode", decode());
    step("jrslot_exec", exec_i(ALU_ADD, 0));
    step("jrslot_wb", wb(0, 1));
    for (int i = 0; i < 3; i++) step("halt_idle", '0);

    // reset out of HALT, undefined opcode returns to FETCH
    reset = 1'b0;
    PcIs0 = 1'b0;
    step("reset_from_halt", '0);
    reset = 1'b1;
    Instr = I_BAD;
    step("bad_fetch", fetch(1));
    step("bad_decode", decode());
    Instr = I_LW;
    step("lw_fetch_after_bad", fetch(1));
    step("lw_decode", decode());
    step("lw_exec", exec_i(ALU_ADD, 0));
    step("lw_mem_accept", mem(1, 1));

    // reset asserted during a stalled load access
    step("lw2_fetch", fetch(1));
    step("lw2_decode", decode());
    step("lw2_exec", exec_i(ALU_ADD, 0));
    waitrequest = 1'b1;
    #1;
    check("lw2_mem_wait", mem(1, 0));
    reset = 1'b0;
    #1;
    check("reset_mid_access", '0);
    @(posedge clk); #1;
    check("reset_mid_held", '0);
    reset = 1'b1;
    waitrequest = 1'b0;
    step("fetch_after_release", fetch(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
